// File: rtl/strip_y_lut.sv
// Programmable strip-ID -> bottom-y table: heights loaded once, lookups served.
// Optional STRIP_Y_TOP_EN adds res_top_o (exclusive top y) per lookup.
module strip_y_lut #(
   parameter int NUM_STRIPS = 13,
   parameter int ID_W       = 4,
   parameter int H_W        = 5,
   parameter int Y_W        = 8,
   parameter int ARRAY_H    = 128
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            clr_i,
   input  logic            cfg_valid_i,
   output logic            cfg_ready_o,
   input  logic [H_W-1:0]  cfg_height_i,
   input  logic            cfg_last_i,
   input  logic            lkp_valid_i,
   output logic            lkp_ready_o,
   input  logic [ID_W-1:0] lkp_id_i,
   output logic            res_valid_o,
   input  logic            res_ready_i,
   output logic [Y_W-1:0]  res_y_o,
   output logic            res_err_o,
`ifdef STRIP_Y_TOP_EN
   output logic [Y_W:0]    res_top_o,
`endif
   output logic            table_rdy_o,
   output logic [ID_W-1:0] count_o,
   output logic            overflow_o
);

   localparam int DEPTH = 2**ID_W;

   typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

   state_t           state, state_n;
   logic             en;
   logic [ID_W-1:0]  count;
   logic [ID_W-1:0]  slot;
   logic [Y_W:0]     base;
   logic [Y_W:0]     base_n;
   logic [Y_W-1:0]   ytab [DEPTH];
   logic [DEPTH-1:0] vtab;
   logic             ovf;
   logic             cfg_fire;
   logic             lkp_fire;
   logic             last_slot;
   logic             fits;
   logic             lkp_err;
`ifdef STRIP_Y_TOP_EN
   logic [H_W-1:0]   htab [DEPTH];
   logic [Y_W:0]     top_n;
`endif

   assign slot      = count + 1'b1;
   assign last_slot = (slot == ID_W'(NUM_STRIPS));
   assign base_n    = base + (Y_W+1)'(cfg_height_i);
   assign fits      = (base_n <= (Y_W+1)'(ARRAY_H));

   assign cfg_ready_o = en && (state != READY) && !clr_i;
   assign lkp_ready_o = en && (state == READY) && !clr_i &&
                        (!res_valid_o || res_ready_i);
   assign cfg_fire    = cfg_valid_i && cfg_ready_o;
   assign lkp_fire    = lkp_valid_i && lkp_ready_o;

   assign lkp_err = (lkp_id_i == '0) || (lkp_id_i > count) ||
                    !vtab[lkp_id_i];
`ifdef STRIP_Y_TOP_EN
   assign top_n = {1'b0, ytab[lkp_id_i]} + (Y_W+1)'(htab[lkp_id_i]);
`endif

   assign table_rdy_o = (state == READY);
   assign count_o     = count;
   assign overflow_o  = ovf;

   // Next-state: load ends on a last beat or when the table fills.
   always_comb begin
      state_n = state;
      if (clr_i) begin
         state_n = EMPTY;
      end else begin
         case (state)
            EMPTY, LOAD:
               if (cfg_fire)
                  state_n = (cfg_last_i || last_slot) ? READY : LOAD;
            default: state_n = state;
         endcase
      end
   end

   // State, prefix-sum base, strip count and sticky overflow.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= EMPTY;
         en    <= 1'b0;
         count <= '0;
         base  <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_n;
         en    <= 1'b1;
         if (clr_i) begin
            count <= '0;
            base  <= '0;
            ovf   <= 1'b0;
         end else if (cfg_fire) begin
            count <= slot;
            base  <= base_n;
            if (!fits)
               ovf <= 1'b1;
         end
      end
   end

   // Table write: entry y is the base before this strip is added.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         vtab <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ytab[i] <= '0;
`ifdef STRIP_Y_TOP_EN
            htab[i] <= '0;
`endif
         end
      end else if (clr_i) begin
         vtab <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ytab[i] <= '0;
`ifdef STRIP_Y_TOP_EN
            htab[i] <= '0;
`endif
         end
      end else if (cfg_fire) begin
         ytab[slot] <= base[Y_W-1:0];
         vtab[slot] <= fits;
`ifdef STRIP_Y_TOP_EN
         htab[slot] <= cfg_height_i;
`endif
      end
   end

   // Result register: loads on accept, holds under backpressure.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         res_valid_o <= 1'b0;
         res_y_o     <= '0;
         res_err_o   <= 1'b0;
`ifdef STRIP_Y_TOP_EN
         res_top_o   <= '0;
`endif
      end else if (clr_i) begin
         res_valid_o <= 1'b0;
      end else if (lkp_fire) begin
         res_valid_o <= 1'b1;
         res_err_o   <= lkp_err;
         res_y_o     <= lkp_err ? '0 : ytab[lkp_id_i];
`ifdef STRIP_Y_TOP_EN
         res_top_o   <= lkp_err ? '0 : top_n;
`endif
      end else if (res_ready_i) begin
         res_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_strip_y_lut.sv
// Scoreboard bench for strip_y_lut: directed loads and lookups.
// Monitor pops expected results whenever a result transfers.
module tb_strip_y_lut;

   logic       clk;
   logic       rst_n;
   logic       clr;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [4:0] cfg_height;
   logic       cfg_last;
   logic       lkp_valid;
   logic       lkp_ready;
   logic [3:0] lkp_id;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_y;
   logic       res_err;
   logic [8:0] res_top;
   logic       table_rdy;
   logic [3:0] count;
   logic       overflow;

   typedef struct {
      logic       err;
      logic [7:0] y;
      logic [8:0] top;
      int         id;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   strip_y_lut dut (
      .clk_i(clk),
      .rst_n_i(rst_n),
      .clr_i(clr),
      .cfg_valid_i(cfg_valid),
      .cfg_ready_o(cfg_ready),
      .cfg_height_i(cfg_height),
      .cfg_last_i(cfg_last),
      .lkp_valid_i(lkp_valid),
      .lkp_ready_o(lkp_ready),
      .lkp_id_i(lkp_id),
      .res_valid_o(res_valid),
      .res_ready_i(res_ready),
      .res_y_o(res_y),
      .res_err_o(res_err),
`ifdef STRIP_Y_TOP_EN
      .res_top_o(res_top),
`endif
      .table_rdy_o(table_rdy),
      .count_o(count),
      .overflow_o(overflow)
   );

`ifndef STRIP_Y_TOP_EN
   assign res_top = '0;
`endif

   initial clk = 0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Result monitor: compares each transferring result with the queue.
   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got y=%0d err=%0d expected none",
                     res_y, res_err);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (res_err !== e.err || res_y !== e.y
`ifdef STRIP_Y_TOP_EN
                || res_top !== e.top
`endif
               ) begin
               errors++;
               $display("FAIL lookup_id%0d: got y=%0d err=%0d top=%0d expected y=%0d err=%0d top=%0d",
                        e.id, res_y, res_err, res_top, e.y, e.err, e.top);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg_beat(input int h, input logic last);
      int n;
      cfg_valid  = 1;
      cfg_height = 5'(h);
      cfg_last   = last;
      #1;
      n = 0;
      while (!cfg_ready && n < 20) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (n >= 20) chk("cfg_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      cfg_valid = 0;
      cfg_last  = 0;
   endtask

   task automatic lookup(input int id, input logic err,
                         input int y, input int top);
      int   n;
      exp_t e;
      lkp_valid = 1;
      lkp_id    = 4'(id);
      #1;
      n = 0;
      while (!lkp_ready && n < 20) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (n >= 20) chk("lkp_ready_timeout", 0, 1);
      e.err = err;
      e.y   = 8'(y);
      e.top = 9'(top);
      e.id  = id;
      q.push_back(e);
      @(posedge clk);
      #1;
      lkp_valid = 0;
   endtask

   task automatic do_clear();
      clr = 1;
      @(posedge clk);
      #1;
      clr = 0;
   endtask

   initial begin
      rst_n = 0; clr = 0; cfg_valid = 0; cfg_height = 0; cfg_last = 0;
      lkp_valid = 0; lkp_id = 0; res_ready = 1;
      cyc(2);
      chk("rst_cfg_ready", int'(cfg_ready), 0);
      chk("rst_table_rdy", int'(table_rdy), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_res_valid", int'(res_valid), 0);
      rst_n = 1;
      cyc(2);

      cfg_beat(16, 0);
      cfg_beat(16, 0);
      cfg_beat(12, 1);
      chk("load3_table_rdy", int'(table_rdy), 1);
      chk("load3_count", int'(count), 3);
      chk("load3_overflow", int'(overflow), 0);
      cfg_valid = 1;
      #1;
      chk("ready_cfg_ready", int'(cfg_ready), 0);
      cfg_valid = 0;
      lookup(3, 0, 32, 44);
      lookup(0, 1, 0, 0);
      lookup(4, 1, 0, 0);
      lookup(2, 0, 16, 32);
      cyc(2);

      res_ready = 0;
      lookup(2, 0, 16, 32);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_res_valid", int'(res_valid), 1);
         chk("bp_res_y", int'(res_y), 16);
         chk("bp_lkp_ready", int'(lkp_ready), 0);
         @(posedge clk);
         #1;
      end
      #1;
      res_ready = 1;
      lookup(1, 0, 0, 16);
      lookup(3, 0, 32, 44);
      cyc(3);
      chk("bp_drained", q.size(), 0);

      do_clear();
      cfg_beat(10, 0);
      chk("clr_reload_count", int'(count), 1);
      do_clear();
      for (int i = 0; i < 13; i++) cfg_beat(10, 0);
      chk("ovf_table_rdy", int'(table_rdy), 1);
      chk("ovf_count", int'(count), 13);
      chk("ovf_flag", int'(overflow), 1);
      lookup(12, 0, 110, 120);
      lookup(13, 1, 0, 0);
      lookup(1, 0, 0, 10);
      cyc(3);

      clr = 1;
      lkp_valid = 1;
      lkp_id = 1;
      #1;
      chk("clr_lkp_ready", int'(lkp_ready), 0);
      @(posedge clk);
      #1;
      clr = 0;
      lkp_valid = 0;
      #1;
      chk("clr_res_valid", int'(res_valid), 0);
      chk("clr_table_rdy", int'(table_rdy), 0);
      chk("clr_count", int'(count), 0);
      chk("clr_overflow", int'(overflow), 0);
      chk("clr_cfg_ready", int'(cfg_ready), 1);

      cfg_beat(5, 0);
      cfg_beat(5, 0);
      rst_n = 0;
      #1;
      chk("arst_count", int'(count), 0);
      chk("arst_cfg_ready", int'(cfg_ready), 0);
      chk("arst_overflow", int'(overflow), 0);
      chk("arst_res_y", int'(res_y), 0);
      cyc(2);
      rst_n = 1;
      cyc(1);
      cfg_beat(8, 0);
      cfg_beat(8, 1);
      chk("reload_count", int'(count), 2);
      lookup(2, 0, 8, 16);
      lookup(3, 1, 0, 0);
      cyc(4);
      chk("final_queue_empty", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
